digit_serial_adder: RTL

//  Parametrised multi-cycle adder: computes {c_out,sum} = a + b + c_in, DIGIT bits per clock.

---
 rtl/digit_serial_adder.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder: {c_out,sum} = a + b + c_in, computed DIGIT bits per clock
// over NDIG = WIDTH/DIGIT cycles, with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready operation handshake for a, b, c_in
//   a, b, c_in        operands and carry in (latched on accept)
//   out_valid/out_ready result handshake for sum, c_out, overflow
//   sum               (a+b+c_in) mod 2^WIDTH
//   c_out             unsigned carry out of the MSB
//   overflow          two's complement overflow
//   busy              high while digits are being added

module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NDIG = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_hold;
    logic [WIDTH-1:0] b_hold;
    logic [WIDTH-1:0] sum_hold;
    logic             carry;
    logic             c_out_hold;
    logic             ovf_hold;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] dsum;
    logic             dcarry;
    logic             accept;
    logic             last;

    // Operands are shifted right one digit per RUN cycle, so the digit being
    // added always sits in the low bits; on the last digit the low bits hold
    // the original MSBs, which is what the overflow test needs.
    always_comb begin
        a_dig = a_hold[DIGIT-1:0];
        b_dig = b_hold[DIGIT-1:0];
        {dcarry, dsum} = (DIGIT+1)'(a_dig) + (DIGIT+1)'(b_dig)
                       + (DIGIT+1)'(carry);
    end

    assign last      = (cnt == CW'(NDIG - 1));
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);
    assign sum       = sum_hold;
    assign c_out     = c_out_hold;
    assign overflow  = ovf_hold;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = in_valid ? RUN : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            carry      <= 1'b0;
            a_hold     <= '0;
            b_hold     <= '0;
            sum_hold   <= '0;
            c_out_hold <= 1'b0;
            ovf_hold   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_hold <= a;
                b_hold <= b;
                carry  <= c_in;
                cnt    <= '0;
            end else if (state == RUN) begin
                a_hold <= a_hold >> DIGIT;
                b_hold <= b_hold >> DIGIT;
                // New digit enters at the top; after NDIG shifts the
                // first digit has reached bit 0.
                sum_hold <= (sum_hold >> DIGIT)
                          | (WIDTH'(dsum) << (WIDTH - DIGIT));
                carry <= dcarry;
                if (last) begin
                    c_out_hold <= dcarry;
                    ovf_hold   <= (a_dig[DIGIT-1] == b_dig[DIGIT-1])
                               && (dsum[DIGIT-1] != a_dig[DIGIT-1]);
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
